hilo_muldiv_engine: RTL and testbench

- Multi-cycle signed multiply/divide engine that sits directly upstream of the Hi and Lo registers in the datapath.
- Takes its operands from the A and B register outputs.
- Produces the hi/lo results together with a div-by-zero flag that the control unit consumes for the exception path.
- Uses a start/busy/done handshake, so the control FSM waits in a single state rather than counting cycles.

---
 rtl/hilo_muldiv_engine.sv | 187 ++++++++++++++++++
 tb/tb_hilo_muldiv_engine.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_engine.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) engine feeding Hi/Lo.
// A start/busy/done handshake lets the control FSM wait in a single state.
module hilo_muldiv_engine #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_FIN
  } state_e;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH:0]     acc_q, acc_d;      // Booth accumulator / division remainder
  logic [WIDTH-1:0]   q_q, q_d;          // multiplier / dividend-quotient
  logic               q1_q, q1_d;
  logic [WIDTH:0]     m_q, m_d;          // sign-extended multiplicand or |divisor|
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  logic [WIDTH:0]     booth_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH+1:0]   trial;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  // NOTE: every *_d gets its default (hold) value first, so no path through this
  // block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    q_d        = q_q;
    q1_d       = q1_q;
    m_d        = m_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    a_mag     = a[WIDTH-1] ? -a : a;
    b_mag     = b[WIDTH-1] ? -b : b;
    booth_sum = acc_q;
    rem_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    trial     = {1'b0, rem_shift} - {1'b0, m_q};

    unique case ({q_q[0], q1_q})
      2'b01:   booth_sum = acc_q + m_q;
      2'b10:   booth_sum = acc_q - m_q;
      default: booth_sum = acc_q;
    endcase

    unique case (state_q)
      S_IDLE: begin
        // A start landing in the done cycle is dropped, not queued.
        if (start && !done_q) begin
          is_div_d  = op;
          cnt_d     = CNT_INIT;
          acc_d     = '0;
          q1_d      = 1'b0;
          neg_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
          neg_rem_d = a[WIDTH-1];
          dz_d      = 1'b0;
          if (!op) begin
            q_d     = a;
            m_d     = {b[WIDTH-1], b};
            state_d = S_MUL;
          end else if (b == '0) begin
            dz_d    = 1'b1;
            state_d = S_FIN;
          end else begin
            q_d     = a_mag;
            m_d     = {1'b0, b_mag};
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        q_d   = {booth_sum[0], q_q[WIDTH-1:1]};
        q1_d  = q_q[0];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) state_d = S_FIX;
      end
      S_DIV: begin
        if (!trial[WIDTH+1]) begin
          acc_d = trial[WIDTH:0];
          q_d   = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rem_shift;
          q_d   = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) state_d = S_FIX;
      end
      S_FIX: begin
        // Truncating division: quotient takes the xor of signs, remainder the dividend's.
        if (is_div_q) begin
          q_d   = neg_quo_q ? -q_q : q_q;
          acc_d = {1'b0, (neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0])};
        end
        state_d = S_FIN;
      end
      S_FIN: begin
        if (!dz_q) begin
          hi_d = acc_q[WIDTH-1:0];
          lo_d = q_q;
        end
        done_d     = 1'b1;
        div_zero_d = dz_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is written only with non-blocking (<=) assignments so
  // every flop samples the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      q_q        <= '0;
      q1_q       <= 1'b0;
      m_q        <= '0;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      q_q        <= q_d;
      q1_q       <= q1_d;
      m_q        <= m_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_engine.sv
// Scoreboard bench for hilo_muldiv_engine: stimulus pushes expected hi/lo/div_zero,
// a negedge monitor pops and compares on every done pulse.
module tb_hilo_muldiv_engine;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  hilo_muldiv_engine #(.WIDTH(W), .CNT_W(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         mon_e;
  int           checks = 0;
  int           passed = 0;
  int           dones_seen = 0;
  int           dones_expected = 0;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;
  logic [W-1:0] held_hi = '0;
  logic [W-1:0] held_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain 64-bit signed arithmetic; SV / and % truncate toward zero.
  function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [W-1:0] prev_hi, input logic [W-1:0] prev_lo);
    exp_t   r;
    longint sx, sy, p, qt, rm;
    sx = signed'(x);
    sy = signed'(y);
    r.dz = 1'b0;
    if (!o) begin
      p    = sx * sy;
      r.hi = p[63:32];
      r.lo = p[31:0];
    end else if (y == '0) begin
      r.hi = prev_hi;
      r.lo = prev_lo;
      r.dz = 1'b1;
    end else begin
      qt   = sx / sy;
      rm   = sx % sy;
      r.hi = rm[31:0];
      r.lo = qt[31:0];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      held_hi = '0;
      held_lo = '0;
    end else if (done) begin
      dones_seen++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", {63'd0, done}, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("hi", hi, mon_e.hi);
        check("lo", lo, mon_e.lo);
        check("div_zero", div_zero, mon_e.dz);
        held_hi = mon_e.hi;
        held_lo = mon_e.lo;
      end
    end else begin
      check("div_zero_outside_done", div_zero, 64'd0);
      check("hi_stable", hi, held_hi);
      check("lo_stable", lo, held_lo);
    end
  end

  task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int glitch_at);
    exp_t e;
    int   n;
    int   exp_lat;
    e = model(o, x, y, model_hi, model_lo);
    model_hi = e.hi;
    model_lo = e.lo;
    sb_q.push_back(e);
    dones_expected++;
    exp_lat = (o && y == '0) ? 2 : 35;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (n == 1) check("busy_after_start", busy, 64'd1);
      if (n == glitch_at) begin
        start = 1'b1; op = ~o; a = $urandom; b = $urandom;
      end else if (n == glitch_at + 1) begin
        start = 1'b0;
      end
      if (done) break;
    end
    check("latency", n, exp_lat);
    check("busy_in_done_cycle", busy, 64'd0);
    // A start presented in the done cycle must be dropped.
    start = 1'b1; op = 1'($urandom); a = $urandom; b = $urandom;
    @(negedge clk);
    start = 1'b0;
    check("start_in_done_ignored", busy, 64'd0);
    check("done_single_cycle", done, 64'd0);
  endtask

  function automatic logic [W-1:0] pick(input int sel);
    case (sel)
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 64'd0);
    check("reset_done", done, 64'd0);
    check("reset_hi", hi, 64'd0);
    check("reset_lo", lo, 64'd0);

    run_op(1'b0, 32'd7, 32'd6, 0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0003, 0);
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(1'b0, 32'd5, 32'd5, 0);
    run_op(1'b1, 32'd5, 32'd0, 0);
    run_op(1'b0, 32'd7, 32'd6, 10);

    // Reset in the middle of a divide: aborted with no done pulse.
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    check("busy_mid_div", busy, 64'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    check("abort_busy", busy, 64'd0);
    check("abort_done", done, 64'd0);
    check("abort_hi", hi, 64'd0);
    check("abort_lo", lo, 64'd0);
    repeat (40) @(negedge clk);

    run_op(1'b1, 32'd100, 32'd7, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(1'($urandom_range(0, 1)), pick($urandom_range(0, 7)),
             pick($urandom_range(0, 7)), 0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 64'd0);
    check("done_count", dones_seen, dones_expected);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
